// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver with anti-ghost blanking and PWM brightness.
// Optional per-digit blinking is compiled in when SEG_SCAN_BLINK_EN is defined.
module seg_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000,
    parameter int BLINK_DIV    = 25000000
) (
    input  logic       clk100_i,
    input  logic       rst_i,
    input  logic [6:0] hex0_i,
    input  logic [6:0] hex1_i,
    input  logic [6:0] hex2_i,
    input  logic [6:0] hex3_i,
    input  logic [3:0] dp_i,
    input  logic [2:0] bright_i,
    input  logic       en_i,
    input  logic [3:0] blink_i,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic [3:0] an_o
);
    localparam int STEP = (REFRESH_DIV - BLANK_CYCLES) / 8;
    localparam int CW   = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] slot_cnt_r;
    logic [1:0]    digit_r;
    logic [6:0]    seg_sh_r;
    logic          dp_sh_r;
    logic [2:0]    bright_sh_r;

    logic          slot_start_s;
    logic [6:0]    hex_sel_s;
    logic [6:0]    cur_seg_s;
    logic          cur_dp_s;
    logic [2:0]    cur_bright_s;
    logic          cur_dark_s;
    logic          dark_new_s;
    logic [31:0]   cnt_ext_s;
    logic [31:0]   win_end_s;
    logic          lit_s;

`ifdef SEG_SCAN_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    logic [BW-1:0] blink_cnt_r;
    logic          blink_phase_r;
    logic          dark_sh_r;

    // Blink time base: free-running half-period counter toggling the phase on wrap.
    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
            dark_sh_r     <= 1'b0;
        end else begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + {{(BW-1){1'b0}}, 1'b1};
            end
            if (slot_start_s) begin
                dark_sh_r <= dark_new_s;
            end else begin
                dark_sh_r <= dark_sh_r;
            end
        end
    end

    assign dark_new_s = blink_phase_r & blink_i[digit_r];
    assign cur_dark_s = slot_start_s ? dark_new_s : dark_sh_r;
`else
    logic unused_blink_s;
    assign unused_blink_s = ^blink_i;
    assign dark_new_s     = 1'b0;
    assign cur_dark_s     = dark_new_s;
`endif

    // Select the incoming digit's pattern and decide whether its anode is lit this cycle.
    always_comb begin
        slot_start_s = (slot_cnt_r == '0);
        case (digit_r)
            2'd0:    hex_sel_s = hex0_i;
            2'd1:    hex_sel_s = hex1_i;
            2'd2:    hex_sel_s = hex2_i;
            2'd3:    hex_sel_s = hex3_i;
            default: hex_sel_s = 7'h7F;
        endcase
        // On the capture cycle the shadows are still stale, so use the live inputs.
        if (slot_start_s) begin
            cur_seg_s    = hex_sel_s;
            cur_dp_s     = dp_i[digit_r];
            cur_bright_s = bright_i;
        end else begin
            cur_seg_s    = seg_sh_r;
            cur_dp_s     = dp_sh_r;
            cur_bright_s = bright_sh_r;
        end
        cnt_ext_s = 32'(slot_cnt_r);
        win_end_s = 32'(BLANK_CYCLES) + (32'(cur_bright_s) + 32'd1) * 32'(STEP);
        lit_s = en_i && !cur_dark_s && (cnt_ext_s >= 32'(BLANK_CYCLES)) && (cnt_ext_s < win_end_s);
    end

    // Slot/digit sequencing, shadow capture and registered display outputs.
    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            slot_cnt_r  <= '0;
            digit_r     <= 2'd0;
            seg_sh_r    <= 7'h7F;
            dp_sh_r     <= 1'b0;
            bright_sh_r <= 3'd0;
            an_o        <= 4'hF;
            seg_o       <= 7'h7F;
            dp_o        <= 1'b1;
        end else begin
            if (slot_cnt_r == SLOT_LAST) begin
                slot_cnt_r <= '0;
                digit_r    <= digit_r + 2'd1;
            end else begin
                slot_cnt_r <= slot_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
            if (slot_start_s) begin
                seg_sh_r    <= hex_sel_s;
                dp_sh_r     <= dp_i[digit_r];
                bright_sh_r <= bright_i;
            end else begin
                seg_sh_r    <= seg_sh_r;
                dp_sh_r     <= dp_sh_r;
                bright_sh_r <= bright_sh_r;
            end
            if (lit_s) begin
                an_o  <= ~(4'b0001 << digit_r);
                seg_o <= cur_seg_s;
                dp_o  <= ~cur_dp_s;
            end else begin
                an_o  <= 4'hF;
                seg_o <= 7'h7F;
                dp_o  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: table-driven input phases with a cycle model feeding an expectation
// queue, plus hand-written mid-slot input change and mid-slot reset sequences.
module tb_seg_scan_driver;
    localparam int RD = 18;
    localparam int BC = 2;
    localparam int BD = 40;
    localparam int ST = (RD - BC) / 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] hex0, hex1, hex2, hex3;
    logic [3:0] dp;
    logic [2:0] bright;
    logic       en;
    logic [3:0] blink;
    logic [6:0] seg_o;
    logic       dp_o;
    logic [3:0] an_o;

    seg_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BLINK_DIV(BD)) dut (
        .clk100_i(clk), .rst_i(rst),
        .hex0_i(hex0), .hex1_i(hex1), .hex2_i(hex2), .hex3_i(hex3),
        .dp_i(dp), .bright_i(bright), .en_i(en), .blink_i(blink),
        .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    typedef struct {
        logic       en;
        logic [2:0] bright;
        logic [6:0] h0, h1, h2, h3;
        logic [3:0] dp;
        logic [3:0] blink;
        int         cycles;
        logic       chk;
        int         low_exp;
    } vec_t;

    exp_t q[$];
    vec_t vecs[6];
    int   n_cmp = 0;
    int   n_err = 0;
    int   low_cnt = 0;

    // Reference model state: cycles since reset release and captured per-slot values.
    int         m_t = 0;
    logic [6:0] m_seg = 7'h7F;
    logic       m_dp = 1'b0;
    logic [2:0] m_br = 3'd0;
    logic       m_dark = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        exp_t       e;
        int         cnt, dig;
        logic       lit;
        logic [3:0] one = 4'b0001;
        logic [6:0] h;
        if (rst) begin
            e = '{4'hF, 7'h7F, 1'b1};
            m_t = 0; m_seg = 7'h7F; m_dp = 1'b0; m_br = 3'd0; m_dark = 1'b0;
        end else begin
            cnt = m_t % RD;
            dig = (m_t / RD) % 4;
            if (cnt == 0) begin
                case (dig)
                    0:       h = hex0;
                    1:       h = hex1;
                    2:       h = hex2;
                    default: h = hex3;
                endcase
                m_seg = h;
                m_dp  = dp[dig];
                m_br  = bright;
`ifdef SEG_SCAN_BLINK_EN
                m_dark = blink[dig] && (((m_t / BD) % 2) == 1);
`else
                m_dark = 1'b0;
`endif
            end
            lit = en && !m_dark && (cnt >= BC) && (cnt < BC + (int'(m_br) + 1) * ST);
            e.an  = lit ? ~(one << dig) : 4'hF;
            e.seg = lit ? m_seg : 7'h7F;
            e.dp  = lit ? ~m_dp : 1'b1;
            m_t++;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("out{an,seg,dp}", 32'({an_o, seg_o, dp_o}), 32'(e));
        if (an_o != 4'hF) low_cnt++;
    endtask

    initial begin
        int n, hits;
        logic found;

        vecs[0] = '{1'b1, 3'd7, 7'h40, 7'h79, 7'h24, 7'h30, 4'b0000, 4'b0000, 144, 1'b1, 64};
        vecs[1] = '{1'b1, 3'd0, 7'h40, 7'h79, 7'h24, 7'h30, 4'b0101, 4'b0000, 144, 1'b1, 8};
        vecs[2] = '{1'b1, 3'd3, 7'h19, 7'h12, 7'h02, 7'h78, 4'b1010, 4'b0000, 144, 1'b1, 32};
        vecs[3] = '{1'b0, 3'd3, 7'h19, 7'h12, 7'h02, 7'h78, 4'b1010, 4'b0000, 100, 1'b1, 0};
`ifdef SEG_SCAN_BLINK_EN
        vecs[4] = '{1'b1, 3'd7, 7'h40, 7'h79, 7'h24, 7'h30, 4'b0000, 4'b0010, 240, 1'b0, 0};
`else
        vecs[4] = '{1'b1, 3'd7, 7'h40, 7'h79, 7'h24, 7'h30, 4'b0000, 4'b0010, 240, 1'b1, 64};
`endif
        vecs[5] = '{1'b1, 3'd7, 7'h40, 7'h79, 7'h24, 7'h30, 4'b0000, 4'b0000, 144, 1'b1, 64};

        rst = 1'b1; en = 1'b0; bright = 3'd0; dp = 4'b0000; blink = 4'b0000;
        hex0 = 7'h7F; hex1 = 7'h7F; hex2 = 7'h7F; hex3 = 7'h7F;
        @(posedge clk);
        #1;
        cycle();
        check("reset_an", 32'(an_o), 32'hF);
        check("reset_seg", 32'(seg_o), 32'h7F);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            en = vecs[v].en; bright = vecs[v].bright; dp = vecs[v].dp; blink = vecs[v].blink;
            hex0 = vecs[v].h0; hex1 = vecs[v].h1; hex2 = vecs[v].h2; hex3 = vecs[v].h3;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                if (c == vecs[v].cycles - 72) low_cnt = 0;
                cycle();
            end
            if (vecs[v].chk) check($sformatf("lowcnt_row%0d", v), 32'(low_cnt), 32'(vecs[v].low_exp));
        end

        // Mid-slot change of hex1 must not show until digit 1's next slot.
        n = 0;
        while (!((m_t % RD) == 9 && ((m_t / RD) % 4) == 1) && n < 100) begin
            cycle();
            n++;
        end
        check("wait_dig1_mid", 32'(n < 100), 32'd1);
        hex1 = 7'h12;
        for (int c = 0; c < 9; c++) begin
            cycle();
            if (an_o == 4'hD) check("hex1_held", 32'(seg_o), 32'h79);
        end
        hits = 0;
        for (int c = 0; c < 72; c++) begin
            cycle();
            if (an_o == 4'hD) begin
                hits++;
                check("hex1_new", 32'(seg_o), 32'h12);
            end
        end
        check("hex1_new_cycles", 32'(hits), 32'd16);

        // Reset in the middle of digit 2's slot.
        n = 0;
        while (!((m_t % RD) == 6 && ((m_t / RD) % 4) == 2) && n < 100) begin
            cycle();
            n++;
        end
        check("wait_dig2_mid", 32'(n < 100), 32'd1);
        rst = 1'b1;
        cycle();
        check("midrst_an", 32'(an_o), 32'hF);
        check("midrst_seg", 32'(seg_o), 32'h7F);
        rst = 1'b0;
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            cycle();
            n++;
            if (an_o != 4'hF) found = 1'b1;
        end
        check("post_rst_first_lit", 32'(n), 32'd3);
        check("post_rst_digit0", 32'(an_o), 32'hE);
        check("post_rst_seg", 32'(seg_o), 32'h40);
        for (int c = 0; c < 40; c++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz slot rate at 100 MHz); SHALL be at least BLANK_CYCLES+8.
REQ-002 Parameter BLANK_CYCLES, 2000, anode-off guard cycles at the start of each slot (anti-ghosting).
REQ-003 Parameter BLINK_DIV, 25000000, cycles per blink half-period (only used when SEG_SCAN_BLINK_EN is defined).
REQ-004 clk100_i  in  1  system clock, 100 MHz; all logic on the rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 hex0_i..hex3_i  in  7 each  active-low segment patterns, bit0=A..bit6=G; hex0_i is the rightmost digit.
REQ-007 dp_i  in  4  decimal-point request per digit, active-high.
REQ-008 bright_i  in  3  brightness level 0..7.
REQ-009 en_i  in  1  display enable, active-high.
REQ-010 blink_i  in  4  per-digit blink request, active-high.
REQ-011 seg_o  out  7  active-low cathodes of the selected digit.
REQ-012 dp_o  out  1  active-low decimal point.
REQ-013 an_o  out  4  active-low anodes, at most one bit low.

Function
REQ-014 Slot counter SHALL count 0..REFRESH_DIV-1 and wrap; digit index (2 bits) SHALL increment, 3 wrapping to 0, on the wrap cycle.
REQ-015 At slot start (slot counter 0), hexN_i, dp_i[N] and bright_i SHALL be captured into shadow registers for the new digit N; mid-slot input changes SHALL NOT affect outputs until the next slot of that digit.
REQ-016 STEP SHALL be (REFRESH_DIV-BLANK_CYCLES)/8 (integer division); the on-window is BLANK_CYCLES <= slot count < BLANK_CYCLES+(bright+1)*STEP.
REQ-017 Anode for digit N SHALL be driven low only inside the on-window, with en_i=1 and no blink suppression; otherwise an_o=4'hF.
REQ-018 seg_o SHALL equal the captured pattern and dp_o the inverted captured dp bit whenever an anode is low; with all anodes off seg_o=7'h7F, dp_o=1.
REQ-019 All outputs SHALL be registered; an_o/seg_o/dp_o SHALL reflect the counter state of the previous cycle (1-cycle latency).
REQ-020 en_i SHALL gate only the anodes; counters SHALL keep running while en_i=0.
REQ-021 bright_i=7 SHALL give an on-window ending at BLANK_CYCLES+8*STEP, never beyond REFRESH_DIV-1.
REQ-022 Digit index and anode pattern SHALL never have two anodes low in the same cycle, including across slot boundaries.

Reset
REQ-023 While rst_i=1 at a clock edge: slot counter=0, digit index=0, shadows=7'h7F/0/0, blink phase=0.
REQ-024 Outputs the cycle after reset: an_o=4'hF, seg_o=7'h7F, dp_o=1.
REQ-025 Reset asserted mid-slot SHALL abort the slot; first slot after release SHALL be digit 0 starting at count 0.

Configuration
REQ-026 Macro SEG_SCAN_BLINK_EN: when defined, a blink counter 0..BLINK_DIV-1 toggles a blink phase on wrap; during phase=1 digit N with captured blink_i[N]=1 SHALL keep an_o=4'hF for its whole slot (blink_i captured with the shadows).
REQ-027 Without SEG_SCAN_BLINK_EN: blink_i SHALL be ignored, no blink counter SHALL be synthesized, port list unchanged.

Verification
(Bench parameters: REFRESH_DIV=18, BLANK_CYCLES=2, BLINK_DIV=40; hence STEP=2.)
REQ-028 Reset, then en_i=1, bright_i=7, hex0_i..hex3_i=7'h40,7'h79,7'h24,7'h30 -> an_o steps 4'hE,4'hD,4'hB,4'h7, each low for 16 cycles after 2 off cycles, seg_o matching per digit.
REQ-029 bright_i=0 -> each anode low exactly 2 cycles per 18-cycle slot; bright_i=3 -> 8 cycles.
REQ-030 Change hex1_i mid-slot of digit 1 -> seg_o unchanged until the next digit-1 slot, 72 cycles later.
REQ-031 en_i=0 for 100 cycles -> an_o=4'hF throughout; on re-enable, digit sequence continues without restart.
REQ-032 Assert rst_i mid-slot of digit 2 -> next-cycle an_o=4'hF, seg_o=7'h7F; after release digit 0 slot begins at count 0.
REQ-033 With SEG_SCAN_BLINK_EN, blink_i=4'b0010 -> digit 1 dark for every slot in alternating 40-cycle phases, other digits unaffected; without the macro digit 1 never dark.
